// File: rtl/decode_ctrl_seq_if.sv
// ID -> EX handshake and control-word bundle of the ID/EX decode controller.
// The master side drives ID and EX-acceptance inputs. The slave side is the controller.
interface decode_ctrl_seq_if;
  logic       id_valid;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       id_ready;
  logic       flush;
  logic       ex_ready;
  logic       ex_valid;
  logic       ex_done;
  logic [6:0] ex_opcode;
  logic       ex_alu_src;
  logic       ex_mem_write;
  logic [2:0] ex_mem_load_type;
  logic [1:0] ex_mem_store_type;
  logic       ex_wb_load;
  logic       ex_wb_reg_file;
  logic       ex_m_op;
  logic [2:0] ex_m_func;
  logic       ex_illegal;
  logic       md_busy;

  modport master (
    output id_valid, opcode, func3, func7, flush, ex_ready,
    input  id_ready, ex_valid, ex_done, ex_opcode, ex_alu_src, ex_mem_write,
           ex_mem_load_type, ex_mem_store_type, ex_wb_load, ex_wb_reg_file,
           ex_m_op, ex_m_func, ex_illegal, md_busy
  );

  modport slave (
    input  id_valid, opcode, func3, func7, flush, ex_ready,
    output id_ready, ex_valid, ex_done, ex_opcode, ex_alu_src, ex_mem_write,
           ex_mem_load_type, ex_mem_store_type, ex_wb_load, ex_wb_reg_file,
           ex_m_op, ex_m_func, ex_illegal, md_busy
  );
endinterface

// File: rtl/decode_ctrl_seq.sv
// RV32IM ID/EX decode controller: decodes the instruction into a registered control word,
// and stalls the stage for multi-cycle MUL/DIV operations.
module decode_ctrl_seq #(
  parameter bit          ENABLE_M    = 1'b1,
  parameter int unsigned MUL_LATENCY = 32'd2,
  parameter int unsigned DIV_LATENCY = 32'd33
) (
  input logic              clk,
  input logic              rst_n,
  decode_ctrl_seq_if.slave bus
);

  localparam int unsigned MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 32'd1);

  localparam logic [CNT_W-1:0] MUL_EXTRA = CNT_W'(MUL_LATENCY - 32'd1);
  localparam logic [CNT_W-1:0] DIV_EXTRA = CNT_W'(DIV_LATENCY - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [6:0] opcode;
    logic       alu_src;
    logic       mem_write;
    logic [2:0] load_type;
    logic [1:0] store_type;
    logic       wb_load;
    logic       wb_reg_file;
    logic       m_op;
    logic [2:0] m_func;
    logic       illegal;
  } ctrl_t;

  // The reset word doubles as the bubble word loaded on retire and flush.
  localparam ctrl_t BUBBLE = {7'b0000000, 1'b0, 1'b0, 3'b111, 2'b11,
                              1'b0, 1'b0, 1'b0, 3'b000, 1'b0};

  function automatic ctrl_t decode(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [6:0] f7);
    ctrl_t w;
    logic  legal;
    w        = BUBBLE;
    w.opcode = op;
    legal    = 1'b1;
    case (op)
      OP_R: begin
        w.wb_reg_file = 1'b1;
        case (f7)
          F7_BASE: legal = 1'b1;
          F7_ALT:  legal = (f3 == 3'b000) || (f3 == 3'b101);
          F7_MULDIV: begin
            legal    = ENABLE_M;
            w.m_op   = ENABLE_M;
            w.m_func = ENABLE_M ? f3 : 3'b000;
          end
          default: legal = 1'b0;
        endcase
      end
      OP_I: begin
        w.alu_src     = 1'b1;
        w.wb_reg_file = 1'b1;
      end
      OP_LOAD: begin
        w.alu_src     = 1'b1;
        w.wb_load     = 1'b1;
        w.wb_reg_file = 1'b1;
        case (f3)
          3'b000:  w.load_type = 3'b000;
          3'b001:  w.load_type = 3'b001;
          3'b010:  w.load_type = 3'b010;
          3'b100:  w.load_type = 3'b011;
          3'b101:  w.load_type = 3'b100;
          default: begin
            w.load_type = 3'b111;
            legal       = 1'b0;
          end
        endcase
      end
      OP_JALR: begin
        w.alu_src     = 1'b1;
        w.wb_reg_file = 1'b1;
      end
      OP_S: begin
        w.mem_write = 1'b1;
        case (f3)
          3'b000:  w.store_type = 2'b00;
          3'b001:  w.store_type = 2'b01;
          3'b010:  w.store_type = 2'b10;
          default: begin
            w.store_type = 2'b11;
            legal        = 1'b0;
          end
        endcase
      end
      OP_B:                    legal = 1'b1;
      OP_JAL, OP_LUI, OP_AUIPC: w.wb_reg_file = 1'b1;
      default:                 legal = 1'b0;
    endcase
    // An illegal encoding must never write memory, the register file, or start MUL/DIV.
    if (!legal) begin
      w.mem_write   = 1'b0;
      w.store_type  = 2'b11;
      w.wb_reg_file = 1'b0;
      w.wb_load     = 1'b0;
      w.m_op        = 1'b0;
      w.m_func      = 3'b000;
      w.illegal     = 1'b1;
    end else begin
      w.illegal     = 1'b0;
    end
    return w;
  endfunction

  ctrl_t            word_q, word_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            dec_s;
  logic             done_s, ready_s, capture_s;

  // Decode and handshake qualifiers.
  always_comb begin
    dec_s     = decode(bus.opcode, bus.func3, bus.func7);
    done_s    = valid_q && bus.ex_ready && (cnt_q == CNT_ZERO);
    ready_s   = !valid_q || done_s;
    capture_s = bus.id_valid && ready_s && !bus.flush;
  end

  // Next state: flush beats capture, capture beats retire, otherwise hold and count down.
  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      word_d  = BUBBLE;
      cnt_d   = CNT_ZERO;
    end else if (capture_s) begin
      valid_d = 1'b1;
      word_d  = dec_s;
      if (dec_s.m_op) begin
        cnt_d = dec_s.m_func[2] ? DIV_EXTRA : MUL_EXTRA;
      end else begin
        cnt_d = CNT_ZERO;
      end
    end else if (done_s) begin
      valid_d = 1'b0;
      word_d  = BUBBLE;
      cnt_d   = CNT_ZERO;
    end else if (valid_q && (cnt_q != CNT_ZERO)) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // ID/EX control register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      word_q  <= BUBBLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.id_ready          = ready_s;
  assign bus.ex_done           = done_s;
  assign bus.ex_valid          = valid_q;
  assign bus.md_busy           = (cnt_q != CNT_ZERO);
  assign bus.ex_opcode         = word_q.opcode;
  assign bus.ex_alu_src        = word_q.alu_src;
  assign bus.ex_mem_write      = word_q.mem_write;
  assign bus.ex_mem_load_type  = word_q.load_type;
  assign bus.ex_mem_store_type = word_q.store_type;
  assign bus.ex_wb_load        = word_q.wb_load;
  assign bus.ex_wb_reg_file    = word_q.wb_reg_file;
  assign bus.ex_m_op           = word_q.m_op;
  assign bus.ex_m_func         = word_q.m_func;
  assign bus.ex_illegal        = word_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_seq.sv
// Self-checking bench for decode_ctrl_seq: directed scenarios plus randomized traffic,
// checked against a transaction-level reference model.
module tb_decode_ctrl_seq;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;
  localparam logic [20:0] BUBBLE = {7'b0000000, 1'b0, 1'b0, 3'b111, 2'b11,
                                    1'b0, 1'b0, 1'b0, 3'b000, 1'b0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_ctrl_seq_if bus0 ();
  decode_ctrl_seq_if bus1 ();

  decode_ctrl_seq #(.ENABLE_M(1'b1), .MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  decode_ctrl_seq #(.ENABLE_M(1'b0), .MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  wire [20:0] dut_word = {bus0.ex_opcode, bus0.ex_alu_src, bus0.ex_mem_write,
                          bus0.ex_mem_load_type, bus0.ex_mem_store_type, bus0.ex_wb_load,
                          bus0.ex_wb_reg_file, bus0.ex_m_op, bus0.ex_m_func, bus0.ex_illegal};

  int n_checks;
  int n_fail;

  // Model: whether a live instruction sits in EX, its word, and how many EX cycles it still needs.
  bit          m_valid;
  logic [20:0] m_word;
  int          m_left;

  function automatic logic [20:0] ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7, input bit en_m);
    bit r, i, ld, jr, s, b, j, lui, aui, bad, mop;
    logic [2:0] lt;
    logic [1:0] st;
    r   = (op == 7'b0110011); i   = (op == 7'b0010011); ld  = (op == 7'b0000011);
    jr  = (op == 7'b1100111); s   = (op == 7'b0100011); b   = (op == 7'b1100011);
    j   = (op == 7'b1101111); lui = (op == 7'b0110111); aui = (op == 7'b0010111);
    bad = !(r | i | ld | jr | s | b | j | lui | aui);
    if (s && f3 > 3'd2) bad = 1'b1;
    if (ld && (f3 == 3'd3 || f3 >= 3'd6)) bad = 1'b1;
    if (r && !(f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) ||
               (f7 == 7'd1 && en_m))) bad = 1'b1;
    mop = r && (f7 == 7'd1) && en_m;
    lt  = 3'b111;
    if (ld && !bad) lt = (f3 == 3'd4) ? 3'b011 : (f3 == 3'd5) ? 3'b100 : f3;
    st  = (s && !bad) ? f3[1:0] : 2'b11;
    return {op, i | ld | jr, s && !bad, lt, st, ld && !bad,
            (r | i | ld | jr | j | lui | aui) && !bad, mop, mop ? f3 : 3'b000, bad};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_word  = BUBBLE;
    m_left  = 0;
  endtask

  // Advances the model by one clock using the inputs currently applied, then moves to the next negedge.
  task automatic tick();
    bit e_done, cap;
    e_done = m_valid && bus0.ex_ready && (m_left == 1);
    cap    = bus0.id_valid && (!m_valid || e_done) && !bus0.flush;
    if (bus0.flush) begin
      model_reset();
    end else if (cap) begin
      m_word  = ref_decode(bus0.opcode, bus0.func3, bus0.func7, 1'b1);
      m_valid = 1'b1;
      m_left  = m_word[4] ? (bus0.func3[2] ? DIV_LAT : MUL_LAT) : 1;
    end else if (e_done) begin
      model_reset();
    end else if (m_valid && m_left > 1) begin
      m_left--;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive0(input bit v, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7);
    bus0.id_valid = v;
    bus0.opcode   = op;
    bus0.func3    = f3;
    bus0.func7    = f7;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (bus0.ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus0.ex_valid); end
    n_checks++;
    if (dut_word !== BUBBLE) begin n_fail++; $display("FAIL reset_word: got %h want %h", dut_word, BUBBLE); end
    n_checks++;
    if (bus0.md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus0.md_busy); end
    n_checks++;
    if (bus0.id_ready !== 1'b1) begin n_fail++; $display("FAIL reset_id_ready: got %b want 1", bus0.id_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_back_to_back();
    bus0.ex_ready = 1'b1;
    drive0(1'b1, 7'b0010011, 3'b000, 7'b0000000);
    #1;
    n_checks++;
    if (bus0.id_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_addi: got %b want 1", bus0.id_ready); end
    tick();
    drive0(1'b1, 7'b0000011, 3'b100, 7'b0000000);
    #1;
    n_checks++;
    if ({bus0.ex_valid, bus0.ex_alu_src, bus0.ex_wb_reg_file, bus0.ex_wb_load} !== 4'b1110) begin
      n_fail++; $display("FAIL b2b_addi_word: got v/alu/wb/ld %b want 1110",
        {bus0.ex_valid, bus0.ex_alu_src, bus0.ex_wb_reg_file, bus0.ex_wb_load});
    end
    n_checks++;
    if ({bus0.ex_done, bus0.id_ready} !== 2'b11) begin n_fail++; $display("FAIL b2b_done_ready: got %b want 11", {bus0.ex_done, bus0.id_ready}); end
    tick();
    drive0(1'b0, 7'b0000000, 3'b000, 7'b0000000);
    #1;
    n_checks++;
    if ({bus0.ex_valid, bus0.ex_mem_load_type, bus0.ex_wb_load, bus0.ex_alu_src} !== 6'b1_011_1_1) begin
      n_fail++; $display("FAIL b2b_lbu_word: got %b want 101111",
        {bus0.ex_valid, bus0.ex_mem_load_type, bus0.ex_wb_load, bus0.ex_alu_src});
    end
    n_checks++;
    if (bus0.id_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_lbu: got %b want 1", bus0.id_ready); end
    tick();
    n_checks++;
    if (bus0.ex_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_retired: got %b want 0", bus0.ex_valid); end
  endtask

  task automatic test_div();
    int busy_cycles;
    int done_pulses;
    busy_cycles = 0;
    done_pulses = 0;
    bus0.ex_ready = 1'b1;
    drive0(1'b1, 7'b0110011, 3'b100, 7'b0000001);
    tick();
    drive0(1'b0, 7'b0000000, 3'b000, 7'b0000000);
    for (int k = 0; k < 32; k++) begin
      #1;
      if (bus0.md_busy === 1'b1 && bus0.id_ready === 1'b0) busy_cycles++;
      if (bus0.ex_done === 1'b1) done_pulses++;
      tick();
    end
    #1;
    n_checks++;
    if (busy_cycles !== 32) begin n_fail++; $display("FAIL div_busy_cycles: got %0d want 32", busy_cycles); end
    n_checks++;
    if (done_pulses !== 0) begin n_fail++; $display("FAIL div_early_done: got %0d want 0", done_pulses); end
    n_checks++;
    if ({bus0.md_busy, bus0.ex_done, bus0.id_ready} !== 3'b011) begin
      n_fail++; $display("FAIL div_final: busy/done/ready got %b want 011", {bus0.md_busy, bus0.ex_done, bus0.id_ready});
    end
    n_checks++;
    if ({bus0.ex_m_op, bus0.ex_m_func} !== 4'b1100) begin n_fail++; $display("FAIL div_mfunc: got %b want 1100", {bus0.ex_m_op, bus0.ex_m_func}); end
    tick();
    n_checks++;
    if ({bus0.ex_valid, bus0.ex_done} !== 2'b00) begin n_fail++; $display("FAIL div_retire: got %b want 00", {bus0.ex_valid, bus0.ex_done}); end
  endtask

  task automatic test_backpressure();
    int stable;
    stable = 0;
    bus0.ex_ready = 1'b0;
    drive0(1'b1, 7'b0100011, 3'b001, 7'b0000000);
    tick();
    drive0(1'b0, 7'b0000000, 3'b000, 7'b0000000);
    for (int k = 0; k < 5; k++) begin
      #1;
      if (bus0.ex_mem_store_type === 2'b01 && bus0.ex_mem_write === 1'b1 &&
          bus0.id_ready === 1'b0 && bus0.ex_done === 1'b0 && bus0.ex_valid === 1'b1) stable++;
      tick();
    end
    n_checks++;
    if (stable !== 5) begin n_fail++; $display("FAIL sh_hold: got %0d stable cycles want 5", stable); end
    bus0.ex_ready = 1'b1;
    #1;
    n_checks++;
    if ({bus0.ex_done, bus0.id_ready} !== 2'b11) begin n_fail++; $display("FAIL sh_release: got %b want 11", {bus0.ex_done, bus0.id_ready}); end
    tick();
    n_checks++;
    if ({bus0.ex_valid, bus0.ex_done, bus0.ex_mem_store_type} !== 4'b0011) begin
      n_fail++; $display("FAIL sh_single_done: got %b want 0011", {bus0.ex_valid, bus0.ex_done, bus0.ex_mem_store_type});
    end
  endtask

  task automatic test_flush();
    bus0.ex_ready = 1'b1;
    drive0(1'b1, 7'b0110011, 3'b000, 7'b0000001);
    tick();
    #1;
    n_checks++;
    if ({bus0.ex_valid, bus0.md_busy, bus0.ex_m_op} !== 3'b111) begin n_fail++; $display("FAIL flush_mul_live: got %b want 111", {bus0.ex_valid, bus0.md_busy, bus0.ex_m_op}); end
    bus0.flush = 1'b1;
    drive0(1'b1, 7'b0010011, 3'b000, 7'b0000000);
    tick();
    bus0.flush = 1'b0;
    drive0(1'b0, 7'b0000000, 3'b000, 7'b0000000);
    #1;
    n_checks++;
    if ({bus0.ex_valid, bus0.md_busy} !== 2'b00) begin n_fail++; $display("FAIL flush_state: got %b want 00", {bus0.ex_valid, bus0.md_busy}); end
    n_checks++;
    if (dut_word !== BUBBLE) begin n_fail++; $display("FAIL flush_bubble: got %h want %h", dut_word, BUBBLE); end
    tick();
    n_checks++;
    if (bus0.ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_capture: got %b want 0", bus0.ex_valid); end
  endtask

  task automatic test_illegal();
    bus0.ex_ready = 1'b1;
    drive0(1'b1, 7'b1111111, 3'b000, 7'b0000000);
    tick();
    drive0(1'b1, 7'b0100011, 3'b011, 7'b0000000);
    #1;
    n_checks++;
    if ({bus0.ex_illegal, bus0.ex_wb_reg_file, bus0.ex_mem_write, bus0.ex_mem_store_type, bus0.ex_opcode} !==
        {1'b1, 1'b0, 1'b0, 2'b11, 7'b1111111}) begin
      n_fail++; $display("FAIL illegal_opcode: got %b want 100111111111",
        {bus0.ex_illegal, bus0.ex_wb_reg_file, bus0.ex_mem_write, bus0.ex_mem_store_type, bus0.ex_opcode});
    end
    tick();
    drive0(1'b0, 7'b0000000, 3'b000, 7'b0000000);
    #1;
    n_checks++;
    if ({bus0.ex_valid, bus0.ex_illegal, bus0.ex_wb_reg_file, bus0.ex_mem_write, bus0.ex_mem_store_type} !== 6'b110011) begin
      n_fail++; $display("FAIL illegal_store_f3: got %b want 110011",
        {bus0.ex_valid, bus0.ex_illegal, bus0.ex_wb_reg_file, bus0.ex_mem_write, bus0.ex_mem_store_type});
    end
    tick();
  endtask

  task automatic test_no_m();
    bus1.ex_ready = 1'b1;
    bus1.id_valid = 1'b1;
    bus1.opcode   = 7'b0110011;
    bus1.func3    = 3'b000;
    bus1.func7    = 7'b0000001;
    tick();
    bus1.id_valid = 1'b0;
    #1;
    n_checks++;
    if ({bus1.ex_valid, bus1.ex_illegal, bus1.ex_m_op, bus1.ex_wb_reg_file, bus1.md_busy} !== 5'b11000) begin
      n_fail++; $display("FAIL no_m_mul: got %b want 11000",
        {bus1.ex_valid, bus1.ex_illegal, bus1.ex_m_op, bus1.ex_wb_reg_file, bus1.md_busy});
    end
    tick();
  endtask

  task automatic test_random();
    logic [6:0] ops [9];
    bit e_done;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111};
    for (int k = 0; k < 800; k++) begin
      int sel;
      logic [6:0] op, f7;
      sel = int'($urandom_range(0, 10));
      op  = (sel < 9) ? ops[sel] : 7'($urandom);
      case ($urandom_range(0, 3))
        0:       f7 = 7'b0000000;
        1:       f7 = 7'b0100000;
        2:       f7 = 7'b0000001;
        default: f7 = 7'($urandom);
      endcase
      drive0($urandom_range(0, 9) < 7, op, 3'($urandom), f7);
      bus0.ex_ready = ($urandom_range(0, 9) < 7);
      bus0.flush    = ($urandom_range(0, 19) == 0);
      #1;
      e_done = m_valid && bus0.ex_ready && (m_left == 1);
      n_checks++;
      if (bus0.ex_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid @%0d: got %b want %b", k, bus0.ex_valid, m_valid); end
      n_checks++;
      if (dut_word !== m_word) begin n_fail++; $display("FAIL rnd_word @%0d: got %h want %h", k, dut_word, m_word); end
      n_checks++;
      if (bus0.ex_done !== e_done) begin n_fail++; $display("FAIL rnd_done @%0d: got %b want %b", k, bus0.ex_done, e_done); end
      n_checks++;
      if (bus0.id_ready !== (!m_valid || e_done)) begin n_fail++; $display("FAIL rnd_id_ready @%0d: got %b want %b", k, bus0.id_ready, !m_valid || e_done); end
      n_checks++;
      if (bus0.md_busy !== (m_valid && m_left > 1)) begin n_fail++; $display("FAIL rnd_busy @%0d: got %b want %b", k, bus0.md_busy, m_valid && m_left > 1); end
      tick();
    end
    bus0.flush = 1'b0;
    drive0(1'b0, 7'b0000000, 3'b000, 7'b0000000);
  endtask

  task automatic test_async_reset();
    bus0.ex_ready = 1'b1;
    drive0(1'b1, 7'b0110011, 3'b101, 7'b0000001);
    tick();
    drive0(1'b0, 7'b0000000, 3'b000, 7'b0000000);
    for (int k = 0; k < 5; k++) tick();
    #1;
    n_checks++;
    if ({bus0.ex_valid, bus0.md_busy} !== 2'b11) begin n_fail++; $display("FAIL arst_pre_div: got %b want 11", {bus0.ex_valid, bus0.md_busy}); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus0.ex_valid, bus0.md_busy, bus0.ex_done, bus0.id_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL arst_state: got %b want 0001", {bus0.ex_valid, bus0.md_busy, bus0.ex_done, bus0.id_ready});
    end
    n_checks++;
    if (dut_word !== BUBBLE) begin n_fail++; $display("FAIL arst_word: got %h want %h", dut_word, BUBBLE); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({bus0.ex_valid, bus0.md_busy} !== 2'b00) begin n_fail++; $display("FAIL arst_after: got %b want 00", {bus0.ex_valid, bus0.md_busy}); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus0.flush    = 1'b0;
    bus0.ex_ready = 1'b0;
    drive0(1'b0, 7'b0000000, 3'b000, 7'b0000000);
    bus1.flush    = 1'b0;
    bus1.ex_ready = 1'b1;
    bus1.id_valid = 1'b0;
    bus1.opcode   = 7'b0000000;
    bus1.func3    = 3'b000;
    bus1.func7    = 7'b0000000;
    model_reset();
    test_reset();
    test_back_to_back();
    test_div();
    test_backpressure();
    test_flush();
    test_illegal();
    test_no_m();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
